// File: rtl/count_scan_display.sv
// count_scan_display: display end for the 8-bit up/down counter.
// The counter value is converted to three BCD digits by a sequential
// shift-add-3 engine. Direction plus decimal count are shown on a
// 4-digit multiplexed, active-low 7-segment display.
module count_scan_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [7:0] value,
    input  logic       mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_U     = 7'h41;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          tick;
    logic [1:0]    digit;
    logic [19:0]   sr;
    logic [2:0]    iter;
    logic [7:0]    capValue;
    logic          capMode;
    logic [11:0]   bcd;
    logic          dispMode;
    logic [11:0]   bcdNext;
    logic          modeNext;

    // Active-low segment pattern for one decimal digit.
    function automatic logic [6:0] segCode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Glyph for a scan slot, including direction letter and leading-zero blanking.
    function automatic logic [6:0] digitSeg(input logic [1:0] d, input logic [11:0] b,
                                            input logic m);
        logic [6:0] s;
        case (d)
            2'd3:    s = m ? SEG_D : SEG_U;
            2'd2:    s = (b[11:8] == 4'd0) ? SEG_BLANK : segCode(b[11:8]);
            2'd1:    s = (b[11:4] == 8'd0) ? SEG_BLANK : segCode(b[7:4]);
            default: s = segCode(b[3:0]);
        endcase
        return s;
    endfunction

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [19:0] ddStep(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    assign tick = (presc == PRESC_LAST);

    // Data the display will hold after this edge, so a DONE on a tick edge lands in the same slot.
    always_comb begin
        bcdNext  = bcd;
        modeNext = dispMode;
        if (state == DONE) begin
            bcdNext  = sr[19:8];
            modeNext = capMode;
        end
    end

    // Scan prescaler: free-running modulo-SCAN_DIV counter.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Digit scanner: on each tick, drive the current digit index and move to the next one.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            digit <= 2'd0;
            an    <= 4'b1111;
            seg   <= SEG_BLANK;
        end else if (tick) begin
            an    <= ~(4'b0001 << digit);
            seg   <= digitSeg(digit, bcdNext, modeNext);
            digit <= digit + 2'd1;
        end
    end

    // Conversion FSM: capture on input change, 8 shift-add-3 steps, then publish the result.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= IDLE;
            sr       <= '0;
            iter     <= '0;
            capValue <= '0;
            capMode  <= 1'b0;
            bcd      <= '0;
            dispMode <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((value != capValue) || (mode != capMode)) begin
                        capValue <= value;
                        capMode  <= mode;
                        sr       <= {12'b0, value};
                        iter     <= '0;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    sr   <= ddStep(sr);
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bcd      <= bcdNext;
                    dispMode <= modeNext;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_scan_display.sv
// tb_count_scan_display: self-checking bench for count_scan_display.
// A decimal-arithmetic reference model predicts seg/an/busy every cycle;
// directed scenarios pin the model with hand-computed glyph values.
module tb_count_scan_display;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       clr_n;
    logic [7:0] value;
    logic       mode;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    bit checkOn  = 0;

    count_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .value(value),
        .mode (mode),
        .seg  (seg),
        .an   (an),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: edge count since reset, conversion window, shown number.
    int         k;
    int         capVal;
    bit         capMode;
    bit         convActive;
    int         convStart;
    int         pendVal;
    bit         pendMode;
    int         shownVal;
    bit         shownMode;
    logic [3:0] expAn;
    logic [6:0] expSeg;
    logic       expBusy;

    logic [6:0] digSeg [4];

    function automatic logic [6:0] glyphOf(input int n);
        case (n)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] expectedDigit(input int d, input int v, input bit m);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (d)
            3: return m ? 7'h21 : 7'h41;
            2: return (h == 0) ? 7'h7F : glyphOf(h);
            1: return (h == 0 && t == 0) ? 7'h7F : glyphOf(t);
            default: return glyphOf(o);
        endcase
    endfunction

    // Model: conversion takes 9 edges from capture; slot d is driven on every SCAN_DIV-th edge.
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            k = 0; capVal = 0; capMode = 0; convActive = 0; convStart = 0;
            pendVal = 0; pendMode = 0; shownVal = 0; shownMode = 0;
            expAn = 4'b1111; expSeg = 7'h7F; expBusy = 1'b0;
        end else begin
            k++;
            if (convActive) begin
                if (k - convStart == 9) begin
                    shownVal   = pendVal;
                    shownMode  = pendMode;
                    convActive = 0;
                end
            end else if (int'(value) != capVal || mode != capMode) begin
                capVal     = int'(value);
                capMode    = mode;
                pendVal    = int'(value);
                pendMode   = mode;
                convActive = 1;
                convStart  = k;
            end
            expBusy = convActive;
            if (k % SCAN_DIV == 0) begin
                int d;
                d      = (k / SCAN_DIV - 1) % 4;
                expAn  = ~(4'b0001 << d);
                expSeg = expectedDigit(d, shownVal, shownMode);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("an", 32'(an), 32'(expAn));
            checkOutput("seg", 32'(seg), 32'(expSeg));
            checkOutput("busy", 32'(busy), 32'(expBusy));
        end
    end

    task automatic applyStimulus(input logic [7:0] v, input logic m);
        @(negedge clk);
        value = v;
        mode  = m;
    endtask

    task automatic measureBusy(output int len);
        int guard;
        guard = 0;
        len   = 0;
        @(negedge clk);
        while (!busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!busy) begin
            len = -1;
            return;
        end
        while (busy && len < 40) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic collectSlots(output int busyHigh);
        busyHigh = 0;
        for (int i = 0; i < 4; i++) digSeg[i] = 7'h55;
        for (int i = 0; i < 5 * SCAN_DIV; i++) begin
            @(negedge clk);
            if (busy) busyHigh++;
            case (an)
                4'b1110: digSeg[0] = seg;
                4'b1101: digSeg[1] = seg;
                4'b1011: digSeg[2] = seg;
                4'b0111: digSeg[3] = seg;
                default: ;
            endcase
        end
    endtask

    task automatic checkSlots(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0);
        int bh;
        collectSlots(bh);
        checkOutput({tag, "_dig3"}, 32'(digSeg[3]), 32'(d3));
        checkOutput({tag, "_dig2"}, 32'(digSeg[2]), 32'(d2));
        checkOutput({tag, "_dig1"}, 32'(digSeg[1]), 32'(d1));
        checkOutput({tag, "_dig0"}, 32'(digSeg[0]), 32'(d0));
    endtask

    initial begin
        int len;
        int bh;
        clr_n = 1'b0;
        value = 8'd0;
        mode  = 1'b0;
        repeat (2) @(posedge clk);
        checkOn = 1;

        // Release with value 0 / mode up: no conversion, first drive at edge SCAN_DIV.
        @(negedge clk);
        clr_n = 1'b1;
        for (int i = 0; i < SCAN_DIV - 1; i++) begin
            @(negedge clk);
            checkOutput("an_before_first_tick", 32'(an), 32'h0000000F);
        end
        @(negedge clk);
        checkOutput("an_first_tick", 32'(an), 32'h0000000E);
        checkOutput("seg_first_tick", 32'(seg), 32'h00000040);
        collectSlots(bh);
        checkOutput("idle_busy_count", 32'(bh), 32'd0);
        checkOutput("zero_dig3", 32'(digSeg[3]), 32'h41);
        checkOutput("zero_dig2", 32'(digSeg[2]), 32'h7F);
        checkOutput("zero_dig1", 32'(digSeg[1]), 32'h7F);
        checkOutput("zero_dig0", 32'(digSeg[0]), 32'h40);

        applyStimulus(8'd255, 1'b0);
        measureBusy(len);
        checkOutput("busy_len_255", 32'(len), 32'd9);
        checkSlots("v255", 7'h41, 7'h24, 7'h12, 7'h12);

        applyStimulus(8'd7, 1'b1);
        measureBusy(len);
        checkOutput("busy_len_7", 32'(len), 32'd9);
        checkSlots("v7down", 7'h21, 7'h7F, 7'h7F, 7'h78);

        applyStimulus(8'd100, 1'b0);
        measureBusy(len);
        checkSlots("v100", 7'h41, 7'h79, 7'h40, 7'h40);

        applyStimulus(8'd9, 1'b0);
        measureBusy(len);
        checkSlots("v9", 7'h41, 7'h7F, 7'h7F, 7'h10);

        // 12 captured, then 13 arrives mid-conversion and is picked up afterwards.
        applyStimulus(8'd12, 1'b0);
        len = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 9 && busy) len++;
            if (i == 2) value = 8'd13;
            if (i == 9) checkOutput("busy_gap", 32'(busy), 32'd0);
        end
        checkOutput("busy_len_12", 32'(len), 32'd9);
        measureBusy(len);
        checkOutput("busy_len_13", 32'(len), 32'd9);
        checkSlots("v13", 7'h41, 7'h7F, 7'h79, 7'h30);

        // Asynchronous reset in the middle of converting 200.
        applyStimulus(8'd200, 1'b0);
        repeat (4) @(negedge clk);
        #1 clr_n = 1'b0;
        #1;
        checkOutput("rst_an", 32'(an), 32'h0000000F);
        checkOutput("rst_seg", 32'(seg), 32'h0000007F);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        measureBusy(len);
        checkOutput("busy_len_200", 32'(len), 32'd9);
        checkSlots("v200", 7'h41, 7'h24, 7'h40, 7'h40);

        // Randomized traffic, occasional short resets; the model checks every cycle.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) != 0)
                applyStimulus(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            else
                applyStimulus(value, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 39) == 0) begin
                #2 clr_n = 1'b0;
                @(negedge clk);
                clr_n = 1'b1;
            end
            repeat ($urandom_range(0, 14)) @(negedge clk);
        end
        repeat (30) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
